// File: rtl/rainbow_sequencer.sv
// RGB rainbow controller: steps three fade channels through a 6-phase, 120-degree rainbow
// and drives one registered PWM output per channel. Optional macro: RAINBOW_SEQ_BRIGHTNESS_EN.
module rainbow_sequencer #(
  parameter int STEP_INTERVAL   = 12000,
  parameter int STEPS_PER_PHASE = 166,
  parameter int PWM_INTERVAL    = 1200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       restart,
`ifdef RAINBOW_SEQ_BRIGHTNESS_EN
  input  logic [7:0] brightness,
`endif
  output logic       red,
  output logic       green,
  output logic       blue,
  output logic [2:0] phase,
  output logic       phase_done
);

  localparam int STEP_VAL  = PWM_INTERVAL / STEPS_PER_PHASE;
  localparam int LEVEL_MAX = STEP_VAL * STEPS_PER_PHASE;
  localparam int LW        = $clog2(PWM_INTERVAL + 1);
  localparam int SPW       = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
  localparam int SCW       = (STEPS_PER_PHASE > 1) ? $clog2(STEPS_PER_PHASE) : 1;
  localparam int PCW       = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;

  typedef logic [LW-1:0] level_t;

  localparam level_t         LVL_MAX  = level_t'(LEVEL_MAX);
  localparam level_t         LVL_STEP = level_t'(STEP_VAL);
  localparam logic [SPW-1:0] PRE_LAST = SPW'(STEP_INTERVAL - 1);
  localparam logic [SCW-1:0] STP_LAST = SCW'(STEPS_PER_PHASE - 1);
  localparam logic [PCW-1:0] PWM_LAST = PCW'(PWM_INTERVAL - 1);

  localparam logic [1:0] M_LO   = 2'd0;
  localparam logic [1:0] M_HI   = 2'd1;
  localparam logic [1:0] M_RISE = 2'd2;
  localparam logic [1:0] M_FALL = 2'd3;

  typedef enum logic [2:0] {
    PH0 = 3'd0, PH1 = 3'd1, PH2 = 3'd2, PH3 = 3'd3, PH4 = 3'd4, PH5 = 3'd5
  } phase_t;

  // Channel behaviour per phase, packed as {R, G, B}.
  function automatic logic [5:0] phase_modes(input phase_t p);
    case (p)
      PH0:     return {M_HI,   M_RISE, M_LO};
      PH1:     return {M_FALL, M_HI,   M_LO};
      PH2:     return {M_LO,   M_HI,   M_RISE};
      PH3:     return {M_LO,   M_FALL, M_HI};
      PH4:     return {M_RISE, M_LO,   M_HI};
      PH5:     return {M_HI,   M_LO,   M_FALL};
      default: return {M_HI,   M_RISE, M_LO};
    endcase
  endfunction

  // The last step of a phase snaps a ramp to its exact endpoint.
  function automatic level_t next_level(input logic [1:0] m, input level_t lv, input logic last);
    case (m)
      M_RISE:  return last ? LVL_MAX : lv + LVL_STEP;
      M_FALL:  return last ? level_t'(0) : lv - LVL_STEP;
      M_HI:    return LVL_MAX;
      default: return level_t'(0);
    endcase
  endfunction

  phase_t         r_phase;
  phase_t         w_phase_next;
  logic [SPW-1:0] r_prescaler;
  logic [SCW-1:0] r_step_cnt;
  logic [PCW-1:0] r_pwm_cnt;
  level_t         r_level [3];
  level_t         w_level_next [3];
  level_t         w_duty [3];
  logic [5:0]     w_modes;
  logic           w_step_tick;
  logic           w_last_step;
  logic           r_phase_done;
  logic [2:0]     r_out;

  assign w_step_tick = enable && (r_prescaler == PRE_LAST);
  assign w_last_step = (r_step_cnt == STP_LAST);
  assign w_modes     = phase_modes(r_phase);

  // Phase state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= PH0;
    end else begin
      r_phase <= w_phase_next;
    end
  end

  // Phase next-state: restart wins over a coincident phase advance.
  always_comb begin
    w_phase_next = r_phase;
    if (restart) begin
      w_phase_next = PH0;
    end else if (w_step_tick && w_last_step) begin
      case (r_phase)
        PH0:     w_phase_next = PH1;
        PH1:     w_phase_next = PH2;
        PH2:     w_phase_next = PH3;
        PH3:     w_phase_next = PH4;
        PH4:     w_phase_next = PH5;
        PH5:     w_phase_next = PH0;
        default: w_phase_next = PH0;
      endcase
    end else begin
      w_phase_next = r_phase;
    end
  end

  // Per-channel level after a step tick.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_level_next[i] = next_level(w_modes[2*(2-i) +: 2], r_level[i], w_last_step);
    end
  end

  // Step timing, levels and phase_done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prescaler  <= '0;
      r_step_cnt   <= '0;
      r_level[0]   <= LVL_MAX;
      r_level[1]   <= '0;
      r_level[2]   <= '0;
      r_phase_done <= 1'b0;
    end else if (restart) begin
      r_prescaler  <= '0;
      r_step_cnt   <= '0;
      r_level[0]   <= LVL_MAX;
      r_level[1]   <= '0;
      r_level[2]   <= '0;
      r_phase_done <= 1'b0;
    end else begin
      r_phase_done <= w_step_tick && w_last_step;
      if (w_step_tick) begin
        r_prescaler <= '0;
        r_step_cnt  <= w_last_step ? '0 : r_step_cnt + SCW'(1);
        for (int i = 0; i < 3; i++) begin
          r_level[i] <= w_level_next[i];
        end
      end else if (enable) begin
        r_prescaler <= r_prescaler + SPW'(1);
      end
    end
  end

`ifdef RAINBOW_SEQ_BRIGHTNESS_EN
  level_t r_duty [3];

  // Brightness-scaled duty, one register stage behind the level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        r_duty[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_duty[i] <= level_t'(({8'd0, r_level[i]} * {{LW{1'b0}}, brightness}) >> 8);
      end
    end
  end

  assign w_duty[0] = r_duty[0];
  assign w_duty[1] = r_duty[1];
  assign w_duty[2] = r_duty[2];
`else
  assign w_duty[0] = r_level[0];
  assign w_duty[1] = r_level[1];
  assign w_duty[2] = r_level[2];
`endif

  // PWM counter and registered comparators; the counter ignores enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= '0;
      r_out     <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_out[i] <= (LW'(r_pwm_cnt) < w_duty[i]);
      end
      if (restart || (r_pwm_cnt == PWM_LAST)) begin
        r_pwm_cnt <= '0;
      end else begin
        r_pwm_cnt <= r_pwm_cnt + PCW'(1);
      end
    end
  end

  assign red        = r_out[0];
  assign green      = r_out[1];
  assign blue       = r_out[2];
  assign phase      = r_phase;
  assign phase_done = r_phase_done;

endmodule

// File: tb/tb_rainbow_sequencer.sv
// Randomized self-checking bench for rainbow_sequencer, with a timeline-based reference model
// plus directed literal checks of the rainbow scenarios.
module tb_rainbow_sequencer;

  localparam int SI  = 4;
  localparam int SPP = 4;
  localparam int PI  = 16;
  localparam int SV  = PI / SPP;
  localparam int LM  = SV * SPP;
  // Per phase, per channel: 0 = low, 1 = high, 2 = rise, 3 = fall (R, G, B).
  localparam int TBL [18] = '{1, 2, 0,  3, 1, 0,  0, 1, 2,  0, 3, 1,  2, 0, 1,  1, 0, 3};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       restart = 1'b0;
  logic       red, green, blue, phase_done;
  logic [2:0] phase;
`ifdef RAINBOW_SEQ_BRIGHTNESS_EN
  logic [7:0] brightness = 8'd255;
`endif

  rainbow_sequencer #(.STEP_INTERVAL(SI), .STEPS_PER_PHASE(SPP), .PWM_INTERVAL(PI)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
`ifdef RAINBOW_SEQ_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .red(red), .green(green), .blue(blue), .phase(phase), .phase_done(phase_done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  // Model state: enabled cycles since restart, and PWM position.
  int   m_e   = 0;
  int   m_pwm = 0;
  logic m_red = 1'b0, m_green = 1'b0, m_blue = 1'b0, m_done = 1'b0;

  function automatic int lvl(input int ch, input int e);
    int t, p, k;
    t = e / SI;
    p = (t / SPP) % 6;
    k = t % SPP;
    case (TBL[p*3 + ch])
      0:       return 0;
      1:       return LM;
      2:       return k * SV;
      default: return LM - k * SV;
    endcase
  endfunction

  function automatic int mphase(input int e);
    return (e / (SI * SPP)) % 6;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_e <= 0; m_pwm <= 0;
      m_red <= 1'b0; m_green <= 1'b0; m_blue <= 1'b0; m_done <= 1'b0;
    end else begin
      m_red   <= (m_pwm < lvl(0, m_e));
      m_green <= (m_pwm < lvl(1, m_e));
      m_blue  <= (m_pwm < lvl(2, m_e));
      m_done  <= !restart && enable && (m_e % SI == SI - 1) && ((m_e / SI) % SPP == SPP - 1);
      m_e     <= restart ? 0 : m_e + (enable ? 1 : 0);
      m_pwm   <= restart ? 0 : (m_pwm + 1) % PI;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // One clock: wait for the falling edge and compare every output against the model.
  task automatic step();
    @(negedge clk);
    chk("red", int'(red), int'(m_red));
    chk("green", int'(green), int'(m_green));
    chk("blue", int'(blue), int'(m_blue));
    chk("phase", int'(phase), mphase(m_e));
    chk("phase_done", int'(phase_done), int'(m_done));
  endtask

  task automatic count_hi(input int n, output int cr, output int cg, output int cb);
    cr = 0; cg = 0; cb = 0;
    for (int i = 0; i < n; i++) begin
      step();
      cr += int'(red); cg += int'(green); cb += int'(blue);
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  initial begin
    int cr, cg, cb, pulses, bad_gap, prev, ph1, ph6, waited;
    logic seen;

    step(); step();
    chk("reset_phase", int'(phase), 0);
    chk("reset_red", int'(red), 0);
    rst_n = 1'b1;

    count_hi(16, cr, cg, cb);
    chk("idle_red_16", cr, 16);
    chk("idle_green_0", cg, 0);
    chk("idle_blue_0", cb, 0);

    // Full rainbow: phase_done every 16 enabled cycles, wrap after 96.
    do_restart();
    enable = 1'b1;
    pulses = 0; bad_gap = 0; prev = 0; ph1 = -1; ph6 = -1;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (phase_done) begin
        pulses++;
        if (i - prev != 16) bad_gap++;
        prev = i;
        if (pulses == 1) ph1 = int'(phase);
        if (pulses == 6) ph6 = int'(phase);
      end
    end
    chk("done_pulses", pulses, 12);
    chk("done_gap_bad", bad_gap, 0);
    chk("phase_after_1st", ph1, 1);
    chk("phase_after_wrap", ph6, 0);

    // Green ramp in phase 0, observed while frozen.
    do_restart();
    enable = 1'b1;
    repeat (4) step();
    enable = 1'b0;
    count_hi(16, cr, cg, cb);
    chk("p0_green_tick1", cg, 4);
    enable = 1'b1;
    repeat (4) step();
    enable = 1'b0;
    count_hi(16, cr, cg, cb);
    chk("p0_green_tick2", cg, 8);

    // Freeze mid phase 2, then resume.
    do_restart();
    enable = 1'b1;
    repeat (38) step();
    enable = 1'b0;
    count_hi(16, cr, cg, cb);
    chk("p2_blue_frozen", cb, 4);
    chk("p2_green_frozen", cg, 16);
    repeat (34) step();
    chk("p2_phase_frozen", int'(phase), 2);
    enable = 1'b1;
    waited = 0; seen = 1'b0;
    while (!seen && waited < 40) begin
      step();
      waited++;
      seen = phase_done;
    end
    chk("p2_resume_cycles", waited, 10);
    chk("p2_resume_phase", int'(phase), 3);

    // Restart on the final tick of phase 3.
    do_restart();
    enable = 1'b1;
    repeat (63) step();
    chk("p3_before_restart", int'(phase), 3);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("restart_phase", int'(phase), 0);
    chk("restart_no_done", int'(phase_done), 0);
    enable = 1'b0;
    count_hi(16, cr, cg, cb);
    chk("restart_red_16", cr, 16);
    chk("restart_green_0", cg, 0);
    chk("restart_blue_0", cb, 0);

    // Random enable / restart / async reset.
    for (int i = 0; i < 3000; i++) begin
      enable  = ($urandom_range(0, 9) < 7);
      restart = ($urandom_range(0, 99) < 2);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
